pi_current_control: RTL and testbench
=====================================

Name: pi_current_control

Overview:
Parametrised proportional-integral successor to the single-channel proportional current loop. It compares the assistance demand against the measured phase-wire current on a programmable update tick. It produces a saturated, unsigned motor drive word with integrator anti-windup, enable/zero-demand gating and an update strobe. It sits between the assistance-requirement logic and the PWM generator, sharing the ADC reading path.

Parameters:
DATA_W, 12, width of demand, measurement and drive words (unsigned)
GAIN_W, 8, width of unsigned KP/KI gain inputs
FRAC_BITS, 4, binary fraction bits of gains (gain 16 = 1.0 at default)
DIV_W, 15, width of update prescaler counter
UPDATE_DIV, 256, clocks per control update (2..2^DIV_W)
ACC_W, DATA_W+GAIN_W+4, integrator accumulator width (signed)

Ports:
CurrentControlClock  in  1  control clock
ResetN  in  1  asynchronous active-low reset
Enable  in  1  loop enable; low forces drive 0 and clears integrator
AssistanceRequirement  in  DATA_W  demanded current (unsigned)
PhaseWireVoltage  in  DATA_W  measured current ADC reading (unsigned)
Kp  in  GAIN_W  proportional gain, sampled at each tick
Ki  in  GAIN_W  integral gain, sampled at each tick
MotorSignal  out  DATA_W  saturated drive word to PWM
UpdateStrobe  out  1  one-cycle pulse when MotorSignal takes a new value
SatHigh  out  1  last update clamped at max
SatLow  out  1  last update clamped at 0

Behaviour:
- One clock (CurrentControlClock); reset asynchronous, active-low (ResetN). All state is cleared on ResetN low, regardless of clock.
- Reset values: MotorSignal=0, UpdateStrobe=0, SatHigh=0, SatLow=0, integrator=0, prescaler=0, FSM=IDLE.
- Prescaler counts 0..UPDATE_DIV-1 and wraps. The tick is asserted for one cycle when the count equals UPDATE_DIV-1.
- FSM states: IDLE -> SAMPLE -> MULT -> SUM -> SAT -> IDLE, one cycle each.
  - IDLE: on tick go to SAMPLE.
  - SAMPLE: register Demand, Meas, Kp, Ki. err = signed(DATA_W+2)({0,Demand}) - ({0,Meas}).
  - MULT: P = Kp*err and Iinc = Ki*err, both signed ACC_W.
  - SUM: Inext = Iacc + Iinc, saturated to the ACC_W signed range (no wrap). u = (P + Inext) >>> FRAC_BITS, arithmetic shift.
  - SAT: compute the output and integrator update (rules below).
- SAT clamp rules:
  - If u > 2^DATA_W-1: MotorSignal = 2^DATA_W-1, SatHigh=1.
  - If u < 0: MotorSignal = 0, SatLow=1.
  - Otherwise MotorSignal = u[DATA_W-1:0] and both Sat flags are 0.
- SAT anti-windup: Iacc <= Inext unless (SatHigh and err>0) or (SatLow and err<0). In those cases Iacc is held.
- UpdateStrobe is high in the cycle after SAT, coincident with the new MotorSignal.
- Latency: tick cycle T -> MotorSignal valid and UpdateStrobe at T+5.
- MotorSignal holds its value between updates.
- Gating: if Enable=0 or the sampled Demand=0, SAT forces MotorSignal=0, Iacc=0 and Sat flags=0. UpdateStrobe still pulses.
- Enable falling mid-pipeline: the in-flight update completes under the gating rule, so the output goes to 0. The prescaler keeps running.
- A tick arriving while the FSM is not IDLE is ignored; this is impossible when UPDATE_DIV>=6.
- Input changes between ticks have no effect. Gains of 0 are legal: Kp=Ki=0 gives drive 0.

Decomposition:
- Package motor_ctrl_pkg: the FSM state enum pi_state_t, the DATA_W/GAIN_W/FRAC_BITS default constants, and a signed saturation function sat_signed.
- Sub-module update_prescaler: counter plus tick generator with parameter UPDATE_DIV, shared with future speed-loop blocks.

Test Plan:
- Reset mid-update: assert ResetN low during MULT -> all outputs 0 immediately (asynchronous). After release the first strobe comes 5 cycles after the first tick.
- Proportional/integral step (Kp=16, Ki=2, Demand=1000, Meas=0):
  - First strobe gives MotorSignal=1125 (P=16000, I=2000, sum 18000>>>4).
  - Second strobe gives 1250.
- High saturation (Kp=16, Ki=2, Demand=4095, Meas=0):
  - MotorSignal=4095 and SatHigh=1.
  - Iacc stays 8190 on subsequent updates.
  - Stepping Meas to 4095 gives output 511 on the next strobe (integrator not wound up).
- Low saturation (Kp=16, Ki=0, Demand=100, Meas=3000) -> MotorSignal=0, SatLow=1.
- Gating: Enable=0 with Demand=2000 -> MotorSignal=0 on every strobe and Iacc=0. The same holds for Enable=1 with Demand=0.
- Timing (UPDATE_DIV=256):
  - Strobe spacing is exactly 256 clocks.
  - Demand changing between ticks does not alter MotorSignal until the next strobe.

Source files
------------

// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the motor current/speed control loops.
package motor_ctrl_pkg;

    localparam int DATA_W_DEF    = 12;
    localparam int GAIN_W_DEF    = 8;
    localparam int FRAC_BITS_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_MULT   = 3'd2,
        ST_SUM    = 3'd3,
        ST_SAT    = 3'd4
    } pi_state_t;

    // Clamp x into the range of a w-bit two's-complement word (w < 64).
    function automatic longint sat_signed(input longint x, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        return x;
    endfunction

endpackage

// File: rtl/update_prescaler.sv
// Free-running 0..UPDATE_DIV-1 counter; o_tick is high while the count sits at its last value.
module update_prescaler #(
    parameter int DIV_W      = 15,
    parameter int UPDATE_DIV = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(UPDATE_DIV - 1);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/pi_current_control.sv
// PI current loop: demand vs. measured current, saturated unsigned drive with anti-windup.
module pi_current_control
    import motor_ctrl_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int GAIN_W     = GAIN_W_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int DIV_W      = 15,
    parameter int UPDATE_DIV = 256,
    parameter int ACC_W      = DATA_W + GAIN_W + 4
) (
    input  logic              CurrentControlClock,
    input  logic              ResetN,
    input  logic              Enable,
    input  logic [DATA_W-1:0] AssistanceRequirement,
    input  logic [DATA_W-1:0] PhaseWireVoltage,
    input  logic [GAIN_W-1:0] Kp,
    input  logic [GAIN_W-1:0] Ki,
    output logic [DATA_W-1:0] MotorSignal,
    output logic              UpdateStrobe,
    output logic              SatHigh,
    output logic              SatLow
);

    localparam int ERR_W = DATA_W + 2;
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] U_MAX = SUM_W'((longint'(1) <<< DATA_W) - 1);

    logic w_tick;

    update_prescaler #(
        .DIV_W      (DIV_W),
        .UPDATE_DIV (UPDATE_DIV)
    ) u_prescaler (
        .i_clk   (CurrentControlClock),
        .i_rst_n (ResetN),
        .o_tick  (w_tick)
    );

    pi_state_t                r_state;
    logic [DATA_W-1:0]        r_dem_p0;
    logic [DATA_W-1:0]        r_meas_p0;
    logic [GAIN_W-1:0]        r_kp_p0;
    logic [GAIN_W-1:0]        r_ki_p0;
    logic signed [ERR_W-1:0]  r_err_p1;
    logic signed [ACC_W-1:0]  r_p_p1;
    logic signed [ACC_W-1:0]  r_iinc_p1;
    logic signed [ACC_W-1:0]  r_inext_p2;
    logic signed [SUM_W-1:0]  r_u_p2;
    logic signed [ACC_W-1:0]  r_iacc;
    logic [DATA_W-1:0]        r_motor;
    logic                     r_strobe;
    logic                     r_sat_hi;
    logic                     r_sat_lo;

    logic signed [ERR_W-1:0]  w_err;
    logic signed [ACC_W-1:0]  w_err_s;
    logic signed [ACC_W-1:0]  w_kp_s;
    logic signed [ACC_W-1:0]  w_ki_s;
    logic signed [ACC_W-1:0]  w_p;
    logic signed [ACC_W-1:0]  w_iinc;
    logic signed [ACC_W-1:0]  w_inext;
    logic signed [SUM_W-1:0]  w_u;
    logic                     w_u_hi;
    logic                     w_u_lo;
    logic                     w_err_pos;
    logic                     w_err_neg;
    logic                     w_gate;
    logic                     w_hold_i;

    // Both operands zero-extended by two bits so the difference cannot overflow.
    assign w_err   = $signed({2'b00, r_dem_p0}) - $signed({2'b00, r_meas_p0});
    assign w_err_s = ACC_W'(w_err);
    assign w_kp_s  = ACC_W'($signed({1'b0, r_kp_p0}));
    assign w_ki_s  = ACC_W'($signed({1'b0, r_ki_p0}));
    assign w_p     = w_kp_s * w_err_s;
    assign w_iinc  = w_ki_s * w_err_s;

    assign w_inext = ACC_W'(sat_signed(longint'(r_iacc) + longint'(r_iinc_p1), ACC_W));
    assign w_u     = (SUM_W'(r_p_p1) + SUM_W'(w_inext)) >>> FRAC_BITS;

    assign w_u_hi    = (r_u_p2 > U_MAX);
    assign w_u_lo    = r_u_p2[SUM_W-1];
    assign w_err_neg = r_err_p1[ERR_W-1];
    assign w_err_pos = !r_err_p1[ERR_W-1] && (r_err_p1 != '0);
    assign w_gate    = !Enable || (r_dem_p0 == '0);
    // Anti-windup looks at the flags from the previous update, not the one being produced.
    assign w_hold_i  = (r_sat_hi && w_err_pos) || (r_sat_lo && w_err_neg);

    always_ff @(posedge CurrentControlClock or negedge ResetN) begin
        if (!ResetN) begin
            r_state    <= ST_IDLE;
            r_dem_p0   <= '0;
            r_meas_p0  <= '0;
            r_kp_p0    <= '0;
            r_ki_p0    <= '0;
            r_err_p1   <= '0;
            r_p_p1     <= '0;
            r_iinc_p1  <= '0;
            r_inext_p2 <= '0;
            r_u_p2     <= '0;
            r_iacc     <= '0;
            r_motor    <= '0;
            r_strobe   <= 1'b0;
            r_sat_hi   <= 1'b0;
            r_sat_lo   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick)
                        r_state <= ST_SAMPLE;
                end
                // p0: capture inputs
                ST_SAMPLE: begin
                    r_dem_p0  <= AssistanceRequirement;
                    r_meas_p0 <= PhaseWireVoltage;
                    r_kp_p0   <= Kp;
                    r_ki_p0   <= Ki;
                    r_state   <= ST_MULT;
                end
                // p1: error and gain products
                ST_MULT: begin
                    r_err_p1  <= w_err;
                    r_p_p1    <= w_p;
                    r_iinc_p1 <= w_iinc;
                    r_state   <= ST_SUM;
                end
                // p2: integrator candidate and scaled control effort
                ST_SUM: begin
                    r_inext_p2 <= w_inext;
                    r_u_p2     <= w_u;
                    r_state    <= ST_SAT;
                end
                // output clamp, gating and integrator commit
                ST_SAT: begin
                    r_strobe <= 1'b1;
                    r_state  <= ST_IDLE;
                    if (w_gate) begin
                        r_motor  <= '0;
                        r_iacc   <= '0;
                        r_sat_hi <= 1'b0;
                        r_sat_lo <= 1'b0;
                    end else begin
                        if (w_u_hi)
                            r_motor <= '1;
                        else if (w_u_lo)
                            r_motor <= '0;
                        else
                            r_motor <= r_u_p2[DATA_W-1:0];
                        r_sat_hi <= w_u_hi;
                        r_sat_lo <= w_u_lo;
                        if (!w_hold_i)
                            r_iacc <= r_inext_p2;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign MotorSignal  = r_motor;
    assign UpdateStrobe = r_strobe;
    assign SatHigh      = r_sat_hi;
    assign SatLow       = r_sat_lo;

endmodule

// File: tb/tb_pi_current_control.sv
// Scoreboard bench for pi_current_control: stimulus queues expected updates, a monitor checks each strobe.
module tb_pi_current_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [11:0] dem = '0;
    logic [11:0] meas = '0;
    logic [7:0]  kp = '0;
    logic [7:0]  ki = '0;
    logic [11:0] motor;
    logic        strobe;
    logic        sat_hi;
    logic        sat_lo;

    typedef struct {
        string       tag;
        logic [11:0] m;
        logic        sh;
        logic        sl;
    } exp_t;

    exp_t   q[$];
    exp_t   mon_e;
    int     n_checks = 0;
    int     n_fail = 0;
    int     strobe_cnt = 0;
    longint cyc = 0;
    longint rel_cyc = 0;
    longint last_cyc = 0;
    bit     first_after_rst = 1'b1;

    pi_current_control dut (
        .CurrentControlClock   (clk),
        .ResetN                (rst_n),
        .Enable                (en),
        .AssistanceRequirement (dem),
        .PhaseWireVoltage      (meas),
        .Kp                    (kp),
        .Ki                    (ki),
        .MotorSignal           (motor),
        .UpdateStrobe          (strobe),
        .SatHigh               (sat_hi),
        .SatLow                (sat_lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe consumes one queued expectation.
    always @(negedge clk) begin
        if (rst_n && strobe) begin
            if (first_after_rst)
                chk("first_strobe_latency", cyc - rel_cyc, 260);
            else
                chk("strobe_spacing", cyc - last_cyc, 256);
            first_after_rst = 1'b0;
            last_cyc = cyc;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: motor=%0d with no expectation queued", motor);
            end else begin
                mon_e = q.pop_front();
                chk({"motor ", mon_e.tag}, longint'(motor), longint'(mon_e.m));
                chk({"sat_high ", mon_e.tag}, longint'(sat_hi), longint'(mon_e.sh));
                chk({"sat_low ", mon_e.tag}, longint'(sat_lo), longint'(mon_e.sl));
            end
            strobe_cnt++;
        end
    end

    task automatic expect_upd(input string tag, input int m, input bit h, input bit l);
        exp_t e;
        e.tag = tag;
        e.m   = 12'(m);
        e.sh  = h;
        e.sl  = l;
        q.push_back(e);
    endtask

    task automatic wait_strobe();
        int n0;
        bit got;
        n0 = strobe_cnt;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (strobe_cnt > n0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_timeout: no strobe within 400 cycles, got 0 expected 1");
        end
    endtask

    task automatic set_in(input bit e, input int d, input int m, input int p, input int i);
        en   = e;
        dem  = 12'(d);
        meas = 12'(m);
        kp   = 8'(p);
        ki   = 8'(i);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
        first_after_rst = 1'b1;
    endtask

    task automatic step(input string tag, input int m, input bit h, input bit l);
        expect_upd(tag, m, h, l);
        wait_strobe();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_motor", longint'(motor), 0);
        chk("reset_strobe", longint'(strobe), 0);
        chk("reset_sat_high", longint'(sat_hi), 0);
        chk("reset_sat_low", longint'(sat_lo), 0);

        set_in(1, 1000, 0, 16, 2);
        release_reset();
        step("pi_step1", 1125, 0, 0);
        step("pi_step2", 1250, 0, 0);

        // Reset asserted while the next update is in MULT.
        repeat (253) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_motor", longint'(motor), 0);
        chk("async_reset_strobe", longint'(strobe), 0);
        chk("async_reset_sat_high", longint'(sat_hi), 0);
        chk("async_reset_sat_low", longint'(sat_lo), 0);
        release_reset();
        step("post_reset_step", 1125, 0, 0);

        // Enable dropped during SUM of the next update.
        expect_upd("enable_fall", 0, 0, 0);
        repeat (254) @(posedge clk);
        #2;
        en = 1'b0;
        wait_strobe();
        en = 1'b1;
        step("after_enable_fall", 1125, 0, 0);

        set_in(0, 2000, 0, 16, 2);
        step("gate_en0_a", 0, 0, 0);
        step("gate_en0_b", 0, 0, 0);
        set_in(1, 1000, 0, 16, 2);
        step("gate_cleared", 1125, 0, 0);
        set_in(1, 0, 0, 16, 2);
        step("gate_dem0", 0, 0, 0);
        set_in(1, 1000, 0, 16, 2);
        step("dem0_cleared", 1125, 0, 0);
        set_in(1, 0, 0, 16, 2);
        step("clear_before_sat", 0, 0, 0);

        set_in(1, 4095, 0, 16, 2);
        step("sat_hi_1", 4095, 1, 0);
        step("sat_hi_2", 4095, 1, 0);
        step("sat_hi_3", 4095, 1, 0);
        set_in(1, 4095, 4095, 16, 2);
        step("no_windup", 511, 0, 0);

        set_in(1, 0, 0, 16, 2);
        step("clear_before_low", 0, 0, 0);
        set_in(1, 100, 3000, 16, 0);
        step("sat_lo_1", 0, 0, 1);
        step("sat_lo_2", 0, 0, 1);
        set_in(1, 500, 0, 0, 0);
        step("zero_gains", 0, 0, 0);

        set_in(1, 2000, 1500, 32, 0);
        step("prop_only", 1000, 0, 0);
        // Demand moves right after a strobe; output must hold until the next one.
        dem = 12'd2100;
        expect_upd("demand_change", 1200, 0, 0);
        repeat (250) @(posedge clk);
        #2;
        chk("hold_between_updates", longint'(motor), 1000);
        wait_strobe();

        chk("queue_drained", longint'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
